// File: rtl/mdu_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op encodings used by
// both the ID decoder and the EX-stage MDU, plus default latencies.
package mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   function automatic logic is_multicycle(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed busy
// window, and serves mthi/mtlo/mfhi/mflo.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic        cancel,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_we_q, pend_we_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   mdu_op_e     op;
   logic [63:0] prod_s, prod_u;
   logic        div_signed, div_zero;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
   logic [31:0] res_hi, res_lo;
   logic        res_we;

   assign op = mdu_op_e'(mdu_op);

   assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      div_signed = (op == MDU_DIV);
      div_zero   = (rt_data == '0);
      a_mag      = (div_signed && rs_data[31]) ? -rs_data : rs_data;
      b_mag      = (div_signed && rt_data[31]) ? -rt_data : rt_data;
      q_mag      = div_zero ? '0 : a_mag / b_mag;
      r_mag      = div_zero ? '0 : a_mag % b_mag;
      quot       = (div_signed && (rs_data[31] ^ rt_data[31])) ? -q_mag : q_mag;
      rem        = (div_signed && rs_data[31]) ? -r_mag : r_mag;
   end

   always_comb begin
      res_hi = rem;
      res_lo = quot;
      res_we = !div_zero;
      if (op == MDU_MULT) begin
         res_hi = prod_s[63:32];
         res_lo = prod_s[31:0];
         res_we = 1'b1;
      end else if (op == MDU_MULTU) begin
         res_hi = prod_u[63:32];
         res_lo = prod_u[31:0];
         res_we = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!cancel) begin
               if (start && is_multicycle(op)) begin
                  state_d   = ST_BUSY;
                  cnt_d     = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_LOAD : DIV_LOAD;
                  pend_hi_d = res_hi;
                  pend_lo_d = res_lo;
                  pend_we_d = res_we;
               end else if (op == MDU_MTHI) begin
                  hi_d = rs_data;
               end else if (op == MDU_MTLO) begin
                  lo_d = rs_data;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (pend_we_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == ST_BUSY);
   assign hi   = hi_q;
   assign lo   = lo_q;

   always_comb begin
      rd_data = '0;
      if (op == MDU_MFHI)      rd_data = hi_q;
      else if (op == MDU_MFLO) rd_data = lo_q;
   end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pushed at issue, popped when busy drops.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset, start, cancel;
   logic [3:0]  mdu_op;
   logic [31:0] rs_data, rt_data;
   logic        busy;
   logic [31:0] hi, lo, rd_data;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } exp_t;

   exp_t        sb[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          issue_cyc;
   logic [31:0] m_hi, m_lo;

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .cancel(cancel),
      .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo),
      .rd_data(rd_data)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; cancel = 1'b0; mdu_op = MDU_NONE; rs_data = '0; rt_data = '0;
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb_, sq, sr;
      longint unsigned ua, ub;
      sa = $signed(a); sb_ = $signed(b); ua = a; ub = b;
      case (op)
         MDU_MULT:  return sa * sb_;
         MDU_MULTU: return ua * ub;
         MDU_DIV: begin
            if (b == 0) return {m_hi, m_lo};
            sq = sa / sb_; sr = sa % sb_;
            return {sr[31:0], sq[31:0]};
         end
         MDU_DIVU: begin
            if (b == 0) return {m_hi, m_lo};
            return {32'(ua % ub), 32'(ua / ub)};
         end
         default: return {m_hi, m_lo};
      endcase
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] e;
      exp_t        x;
      e = model(op, a, b);
      x.hi = e[63:32]; x.lo = e[31:0];
      x.n  = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_N : DIV_N;
      sb.push_back(x);
      start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
      tick();
      issue_cyc = cyc;
      idle_inputs();
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string tag);
      int   g;
      exp_t x;
      g = 0;
      while (busy === 1'b1 && g < 200) begin
         tick();
         g++;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         x = sb.pop_front();
         chk({tag, "_busy_cycles"}, 64'(cyc - issue_cyc), 64'(x.n));
         chk({tag, "_hi"}, hi, x.hi);
         chk({tag, "_lo"}, lo, x.lo);
         m_hi = x.hi; m_lo = x.lo;
      end
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] v, input logic c);
      mdu_op = op; rs_data = v; cancel = c;
      tick();
      idle_inputs();
      if (!c && op == MDU_MTHI) m_hi = v;
      if (!c && op == MDU_MTLO) m_lo = v;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] op, input logic [31:0] exp);
      mdu_op = op;
      #1;
      chk(tag, rd_data, exp);
      mdu_op = MDU_NONE;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);

      issue(MDU_MULT, 32'hFFFF_FFFF, 32'h2);   wait_done("mult");
      read_chk("mflo_mult", MDU_MFLO, 32'hFFFF_FFFE);
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h2);  wait_done("multu");
      chk("multu_hi_const", hi, 32'h1);
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);    wait_done("div_neg");
      chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
      issue(MDU_DIVU, 32'h7, 32'h2);           wait_done("divu");
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf");
      issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000); wait_done("mult_min");
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom_range(1, 1000) * (i[0] ? 32'hFFFF_FFFF : 32'h1);
         issue(MDU_DIV + 4'(i >> 1), a, b);    wait_done("div_rand");
      end

      mt(MDU_MTHI, 32'hAAAA, 1'b0);
      mt(MDU_MTLO, 32'h5555, 1'b0);
      issue(MDU_DIV, 32'h1234, 32'h0);         wait_done("div0");
      chk("div0_hi_const", hi, 32'hAAAA);

      mt(MDU_MTHI, 32'h1234, 1'b0);
      read_chk("mfhi", MDU_MFHI, 32'h1234);
      read_chk("none_rd", MDU_NONE, 32'h0);
      read_chk("mtlo_rd", MDU_MTLO, 32'h0);

      start = 1'b1; cancel = 1'b1; mdu_op = MDU_MULT; rs_data = 32'h3; rt_data = 32'h4;
      tick();
      idle_inputs();
      chk("cancel_busy", busy, 0);
      tick();
      chk("cancel_hi", hi, m_hi);
      chk("cancel_lo", lo, m_lo);
      mt(MDU_MTHI, 32'h9999, 1'b1);
      chk("cancel_mthi", hi, 32'h1234);

      issue(MDU_MULT, 32'h1234_5678, 32'h10);
      tick();
      start = 1'b1; mdu_op = MDU_DIV; rs_data = 32'd100; rt_data = 32'd3;
      tick();
      idle_inputs();
      mdu_op = MDU_MTLO; rs_data = 32'h99;
      tick();
      idle_inputs();
      chk("overlap_busy", busy, 1);
      wait_done("overlap");
      tick();
      chk("overlap_no_restart", busy, 0);

      issue(MDU_MULT, 32'h7, 32'h9);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(sb.pop_back());
      m_hi = '0; m_lo = '0;
      chk("midrst_busy", busy, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      repeat (MULT_N) tick();
      chk("midrst_no_commit", {hi, lo}, 64'h0);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
